// File: rtl/round_share_arbiter_pkg.sv
// Shared constants, width helper and channel-index type for the round-share arbiter slice.
package round_share_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    localparam int unsigned DefNumCh    = 4;
    localparam int unsigned DefInWidth  = 35;
    localparam int unsigned DefOutWidth = 17;
    localparam int unsigned DefDepth    = 2;

    // Rounding constants for the default build: S, H = 2^(S-1), positive saturation value.
    localparam int unsigned       DefShift  = DefInWidth - DefOutWidth;
    localparam longint unsigned   DefHalf   = 64'd1 << (DefShift - 1);
    localparam longint unsigned   DefSatPos = (64'd1 << (DefOutWidth - 1)) - 64'd1;

    typedef logic [clog2(DefNumCh)-1:0] chan_t;

endpackage

// File: rtl/round_share_arbiter_if.sv
// Producer/consumer bus of the round-share arbiter: channel samples in, rounded tagged result out.
interface round_share_arbiter_if
    import round_share_pkg::*;
#(
    parameter int unsigned NumCh    = DefNumCh,
    parameter int unsigned InWidth  = DefInWidth,
    parameter int unsigned OutWidth = DefOutWidth
);
    localparam int unsigned ChW = clog2(NumCh);

    logic [NumCh*InWidth-1:0] Data_i;
    logic [NumCh-1:0]         DataNd_i;
    logic [NumCh-1:0]         Full_o;
    logic                     ClrOvf_i;
    logic [NumCh-1:0]         Overflow_o;
    logic [OutWidth-1:0]      Data_o;
    logic [ChW-1:0]           Chan_o;
    logic                     DataValid_o;

    modport master (
        output Data_i, DataNd_i, ClrOvf_i,
        input  Full_o, Overflow_o, Data_o, Chan_o, DataValid_o
    );

    modport slave (
        input  Data_i, DataNd_i, ClrOvf_i,
        output Full_o, Overflow_o, Data_o, Chan_o, DataValid_o
    );

endinterface

// File: rtl/round_sym_stage.sv
// Single registered symmetric-rounding adder (half away from zero) with positive saturation.
module round_sym_stage
    import round_share_pkg::*;
#(
    parameter int unsigned InWidth  = DefInWidth,
    parameter int unsigned OutWidth = DefOutWidth,
    parameter int unsigned ChW      = clog2(DefNumCh)
) (
    input  logic                Clk_i,
    input  logic                Rst_i,
    input  logic                in_vld,
    input  logic [InWidth-1:0]  in_data,
    input  logic [ChW-1:0]      in_chan,
    output logic                out_vld,
    output logic [OutWidth-1:0] out_data,
    output logic [ChW-1:0]      out_chan
);
    localparam int unsigned         Shift  = InWidth - OutWidth;
    localparam logic [InWidth:0]    Half   = (InWidth+1)'(1) << (Shift - 1);
    localparam logic [OutWidth-1:0] SatPos = {1'b0, {(OutWidth-1){1'b1}}};

    logic                neg;
    logic [InWidth:0]    sum;
    logic                sat;
    logic [OutWidth-1:0] rnd;
    logic                unused_low;

    // Negative inputs add H-1 so that exact halves round away from zero on both sides.
    always_comb begin
        neg = in_data[InWidth-1];
        sum = {in_data[InWidth-1], in_data} + Half - (InWidth+1)'(neg);
        sat = !neg && (sum[InWidth] != sum[InWidth-1]);
        rnd = sat ? SatPos : sum[InWidth-1 -: OutWidth];
    end

    assign unused_low = ^sum[Shift-1:0];

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_chan <= '0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_data <= rnd;
                out_chan <= in_chan;
            end
        end
    end

endmodule

// File: rtl/round_share_arbiter.sv
// Per-channel holding FIFOs drained round-robin, one sample per cycle, into a shared rounding stage.
module round_share_arbiter
    import round_share_pkg::*;
#(
    parameter int unsigned NumCh    = DefNumCh,
    parameter int unsigned InWidth  = DefInWidth,
    parameter int unsigned OutWidth = DefOutWidth,
    parameter int unsigned Depth    = DefDepth
) (
    input logic                   Clk_i,
    input logic                   Rst_i,
    round_share_arbiter_if.slave  bus
);
    localparam int unsigned      ChW      = clog2(NumCh);
    localparam int unsigned      PtrW     = clog2(Depth);
    localparam int unsigned      CntW     = clog2(Depth + 1);
    localparam logic [CntW-1:0]  DepthCnt = CntW'(Depth);

    logic [NumCh-1:0]   nonempty;
    logic [NumCh-1:0]   full_q;
    logic [NumCh-1:0]   ovf_q;
    logic [InWidth-1:0] head [NumCh];
    logic [ChW-1:0]     last_q;
    logic [ChW-1:0]     gnt;
    logic               gnt_vld;

    // Search upward from the channel after the last grant, wrapping once around.
    always_comb begin
        logic [ChW-1:0] idx;
        gnt     = last_q;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int unsigned i = 1; i <= NumCh; i++) begin
            idx = ChW'((32'(last_q) + i) % NumCh);
            if (!gnt_vld && nonempty[idx]) begin
                gnt     = idx;
                gnt_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            last_q <= ChW'(NumCh - 1);
        end else if (gnt_vld) begin
            last_q <= gnt;
        end
    end

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        logic [InWidth-1:0] mem_q [Depth];
        logic [PtrW-1:0]    wr_ptr_q;
        logic [PtrW-1:0]    rd_ptr_q;
        logic [CntW-1:0]    cnt_q;
        logic [CntW-1:0]    cnt_nxt;
        logic               full_r;
        logic               ovf_r;
        logic               pop;
        logic               push;
        logic               drop;

        // A full FIFO still accepts a sample when it is being popped in the same cycle.
        assign pop     = gnt_vld && (gnt == ChW'(c));
        assign push    = bus.DataNd_i[c] && ((cnt_q != DepthCnt) || pop);
        assign drop    = bus.DataNd_i[c] && !push;
        assign cnt_nxt = cnt_q + CntW'(push) - CntW'(pop);

        always_ff @(posedge Clk_i or posedge Rst_i) begin
            if (Rst_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                full_r   <= 1'b0;
                ovf_r    <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                cnt_q  <= cnt_nxt;
                full_r <= (cnt_nxt == DepthCnt);
                if (drop)              ovf_r <= 1'b1;
                else if (bus.ClrOvf_i) ovf_r <= 1'b0;
            end
        end

        always_ff @(posedge Clk_i) begin
            if (push) mem_q[wr_ptr_q] <= bus.Data_i[c*InWidth +: InWidth];
        end

        assign nonempty[c] = (cnt_q != '0);
        assign head[c]     = mem_q[rd_ptr_q];
        assign full_q[c]   = full_r;
        assign ovf_q[c]    = ovf_r;
    end

    assign bus.Full_o     = full_q;
    assign bus.Overflow_o = ovf_q;

    round_sym_stage #(
        .InWidth  (InWidth),
        .OutWidth (OutWidth),
        .ChW      (ChW)
    ) u_round (
        .Clk_i    (Clk_i),
        .Rst_i    (Rst_i),
        .in_vld   (gnt_vld),
        .in_data  (head[gnt]),
        .in_chan  (gnt),
        .out_vld  (bus.DataValid_o),
        .out_data (bus.Data_o),
        .out_chan (bus.Chan_o)
    );

endmodule

// File: tb/tb_round_share_arbiter.sv
// Scoreboard bench: queue-based reference model predicts grants and rounded results per clock edge.
module tb_round_share_arbiter;
    import round_share_pkg::*;

    localparam int NCh   = 4;
    localparam int InW   = 35;
    localparam int OutW  = 17;
    localparam int Dep   = 2;
    localparam int S     = InW - OutW;
    localparam longint MaxPos = (64'sd1 <<< (InW - 1)) - 1;

    typedef struct packed {
        chan_t           chan;
        logic [OutW-1:0] data;
    } exp_t;

    logic clk;
    logic rst;

    round_share_arbiter_if #(.NumCh(NCh), .InWidth(InW), .OutWidth(OutW)) bus ();

    round_share_arbiter #(
        .NumCh    (NCh),
        .InWidth  (InW),
        .OutWidth (OutW),
        .Depth    (Dep)
    ) dut (
        .Clk_i (clk),
        .Rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    exp_t             exp_q[$];
    logic [InW-1:0]   mq[NCh][$];
    logic [NCh-1:0]   ovf_m;
    int               last_m;
    logic [InW-1:0]   stim_d[NCh];

    function automatic logic [OutW-1:0] ref_round(input logic [InW-1:0] x);
        longint v;
        longint y;
        logic [OutW-1:0] r;
        v = longint'($signed(x));
        if (v >= 0) begin
            y = v + longint'(DefHalf);
            if (y > MaxPos) r = OutW'(DefSatPos);
            else begin
                y = y >>> S;
                r = y[OutW-1:0];
            end
        end else begin
            y = (v + longint'(DefHalf) - 1) >>> S;
            r = y[OutW-1:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCh; c++) mq[c].delete();
        exp_q.delete();
        ovf_m  = '0;
        last_m = NCh - 1;
    endtask

    // One clock edge: grant from pre-edge occupancy, then accept or drop new samples.
    task automatic model_edge(input logic [NCh-1:0] nd, input logic clr);
        int   g;
        exp_t e;
        logic [NCh-1:0] dropped;
        g = -1;
        for (int i = 1; i <= NCh; i++) begin
            int idx;
            idx = (last_m + i) % NCh;
            if (g < 0 && mq[idx].size() > 0) g = idx;
        end
        if (g >= 0) begin
            e.chan = chan_t'(g);
            e.data = ref_round(mq[g].pop_front());
            exp_q.push_back(e);
            last_m = g;
        end
        dropped = '0;
        for (int c = 0; c < NCh; c++) begin
            if (nd[c]) begin
                if (mq[c].size() < Dep) mq[c].push_back(stim_d[c]);
                else dropped[c] = 1'b1;
            end
        end
        for (int c = 0; c < NCh; c++) begin
            if (dropped[c])  ovf_m[c] = 1'b1;
            else if (clr)    ovf_m[c] = 1'b0;
        end
    endtask

    task automatic check_vec(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic [NCh-1:0] nd, input logic clr);
        logic [NCh-1:0] full_m;
        for (int c = 0; c < NCh; c++) bus.Data_i[c*InW +: InW] = stim_d[c];
        bus.DataNd_i = nd;
        bus.ClrOvf_i = clr;
        @(posedge clk);
        model_edge(nd, clr);
        #1;
        for (int c = 0; c < NCh; c++) full_m[c] = (mq[c].size() == Dep);
        check_vec("Full_o", 64'(bus.Full_o), 64'(full_m));
        check_vec("Overflow_o", 64'(bus.Overflow_o), 64'(ovf_m));
        bus.DataNd_i = '0;
        bus.ClrOvf_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_vec("rst Data_o", 64'(bus.Data_o), 64'd0);
        check_vec("rst Chan_o", 64'(bus.Chan_o), 64'd0);
        check_vec("rst DataValid_o", 64'(bus.DataValid_o), 64'd0);
        check_vec("rst Full_o", 64'(bus.Full_o), 64'd0);
        check_vec("rst Overflow_o", 64'(bus.Overflow_o), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: every predicted result must appear on the cycle after its grant edge.
    always @(negedge clk) begin
        if (bus.DataValid_o) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected result: chan %0d data %0h with nothing expected at %0t",
                         bus.Chan_o, bus.Data_o, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_vec("Chan_o", 64'(bus.Chan_o), 64'(e.chan));
                check_vec("Data_o", 64'(bus.Data_o), 64'(e.data));
            end
        end else if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing result: DataValid_o 0, expected chan %0d data %0h at %0t",
                     e.chan, e.data, $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [InW-1:0] pick_value();
        logic [InW-1:0] v;
        case ($urandom_range(0, 7))
            0: v = InW'(MaxPos);
            1: v = InW'(-MaxPos - 1);
            2: v = InW'(DefHalf);
            3: v = InW'(-longint'(DefHalf));
            4: v = InW'(DefHalf - 1);
            5: v = InW'(-longint'(DefHalf) + 1);
            default: v = InW'({$urandom(), $urandom()});
        endcase
        return v;
    endfunction

    initial begin
        logic [InW-1:0] dir_vals[7];
        dir_vals[0] = 35'h0_0004_0000;
        dir_vals[1] = 35'h0_0001_FFFF;
        dir_vals[2] = 35'h0_0002_0000;
        dir_vals[3] = InW'(-64'sd131072);
        dir_vals[4] = InW'(-64'sd131071);
        dir_vals[5] = 35'h3_FFFF_FFFF;
        dir_vals[6] = 35'h4_0000_0000;

        rst = 1'b1;
        bus.Data_i   = '0;
        bus.DataNd_i = '0;
        bus.ClrOvf_i = 1'b0;
        for (int c = 0; c < NCh; c++) stim_d[c] = '0;
        apply_reset();

        // Rounding and saturation on channel 0 alone.
        for (int i = 0; i < 7; i++) begin
            stim_d[0] = dir_vals[i];
            step(4'b0001, 1'b0);
            step('0, 1'b0);
            step('0, 1'b0);
        end

        // Two simultaneous bursts: rotation order must repeat.
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < NCh; c++) stim_d[c] = InW'(64'h40000 * (c + 1));
            step('1, 1'b0);
            repeat (6) step('0, 1'b0);
        end

        // Overfill every channel, then clear with a concurrent drop, then clear alone.
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < NCh; c++) stim_d[c] = InW'(64'h40000 * (k * NCh + c + 1));
            step('1, 1'b0);
        end
        for (int c = 0; c < NCh; c++) stim_d[c] = InW'(64'h80000 * (c + 1));
        step('1, 1'b1);
        repeat (3) step('0, 1'b0);
        step('0, 1'b1);
        repeat (8) step('0, 1'b0);

        // Reset with data queued, then confirm clean restart from channel 0.
        for (int c = 0; c < NCh; c++) stim_d[c] = pick_value();
        step('1, 1'b0);
        step('1, 1'b0);
        apply_reset();
        repeat (2) step('0, 1'b0);
        for (int c = 0; c < NCh; c++) stim_d[c] = InW'(64'h40000 * (NCh - c));
        step('1, 1'b0);
        repeat (6) step('0, 1'b0);

        // Randomized traffic with varying strobe density and occasional clears.
        for (int k = 0; k < 400; k++) begin
            logic [NCh-1:0] nd;
            int dens;
            dens = (k < 200) ? 2 : 6;
            for (int c = 0; c < NCh; c++) begin
                stim_d[c] = pick_value();
                nd[c] = ($urandom_range(0, 7) < dens);
            end
            step(nd, ($urandom_range(0, 15) == 0));
        end

        repeat (12) step('0, 1'b0);
        check_vec("drain queue empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/round_share_arbiter.md
# round_share_arbiter

Shares one symmetric-rounding stage between NumCh independent wide-data producers, such as filter or MAC channels. Each channel pushes full-precision samples with a new-data strobe into a small per-channel holding FIFO. A round-robin arbiter drains one sample per cycle into the rounding stage. The block emits a narrow rounded result tagged with its source channel, and sits between the accumulator bank and the narrow-width output formatter.

## Interface
Parameters:
- NumCh, 4, number of requesting channels (2..8)
- InWidth, 35, signed input sample width
- OutWidth, 17, signed output width; must be < InWidth
- Depth, 2, holding-FIFO entries per channel (power of two, ≥2)

Ports:
- Clk_i  in  1  clock; all logic on rising edge
- Rst_i  in  1  reset, asynchronous, active-high
- Data_i  in  NumCh*InWidth  channel c sample at bits [c*InWidth +: InWidth], two's complement
- DataNd_i  in  NumCh  per-channel new-data strobe, one sample per high cycle
- Full_o  out  NumCh  registered; bit c high when FIFO c holds Depth entries
- ClrOvf_i  in  1  synchronous clear of Overflow_o, all bits
- Overflow_o  out  NumCh  sticky; bit c set when a channel-c sample was dropped
- Data_o  out  OutWidth  rounded result, registered
- Chan_o  out  clog2(NumCh)  source channel of Data_o, registered
- DataValid_o  out  1  one-cycle pulse qualifying Data_o/Chan_o

## Operation
- **Write:**
  - DataNd_i[c] writes Data_i slice c into FIFO c if count_c < Depth, or if channel c is granted in the same cycle (simultaneous pop frees a slot).
  - Otherwise the sample is dropped and Overflow_o[c] sets.
- **Overflow_o:**
  - Holds until ClrOvf_i.
  - If ClrOvf_i and a new drop occur in the same cycle, the set wins.
- **Arbitration:**
  - Each cycle, the grant goes to the first non-empty channel searching upward (with wrap) from lastGrant+1.
  - lastGrant resets to NumCh-1, so channel 0 has first priority after reset.
  - lastGrant updates only on a grant.
  - No grant is issued when all FIFOs are empty.
- **Rounding of the granted sample x:**
  - Let S = InWidth-OutWidth and H = 2^(S-1).
  - If x ≥ 0: y = x + H. If x < 0: y = x + H - 1. This rounds half away from zero.
  - Compute the sum at InWidth+1 bits.
  - If x ≥ 0 and the sum exceeds the max positive InWidth value, saturate Data_o to 2^(OutWidth-1)-1.
  - Otherwise Data_o = y[InWidth-1 -: OutWidth].
  - The negative path cannot overflow.
- **Ordering:** within a channel, output order equals input order. Across channels, order follows the round-robin rotation.
- **Reset:**
  - Asserting Rst_i at any time empties all FIFOs and discards any in-flight result without emitting it.
  - All outputs, lastGrant and the sticky flags go to their reset values.

## Timing
- Reset values: Data_o=0, Chan_o=0, DataValid_o=0, Full_o=0, Overflow_o=0, all FIFO counts 0, lastGrant=NumCh-1.
- Latency:
  - A sample written at edge n into an otherwise empty, ungranted-competition FIFO can be granted in cycle n..n+1.
  - Its result is registered at edge n+1, so DataValid_o is high for the cycle after edge n+1.
  - Minimum latency is 2 edges from strobe to result.
- Throughput is one result per cycle in aggregate; a single continuously strobing channel alone sustains one per cycle.
- Full_o reflects the post-edge count. Producers treat it as advisory; drops are reported, not back-pressured.
- DataValid_o deasserts in any cycle with no grant, so there are no gaps inside a grant but bubbles are allowed.

## Structure
- Package round_share_pkg holds:
  - clog2 function
  - localparam computation of S, H and the positive saturation value
  - a typedef for the channel index
- Sub-module round_sym_stage contains the single registered rounding adder with saturation, takes the sample plus channel tag, and is instantiated once.
- FIFOs are generated per channel: storage, read/write pointers and count. The arbiter is an in-line combinational search plus the lastGrant register.

## Test plan
Defaults throughout: InWidth=35, OutWidth=17, S=18, H=0x20000.
- **Rounding values:** channel 0 alone, inputs 0x40000, 0x1FFFF, 0x20000, -0x20000, -0x1FFFF → Data_o = 1, 0, 1, 0x1FFFF (-1), 0; Chan_o=0 on each; latency 2 edges.
- **Saturation:** input 0x3_FFFF_FFFF (max positive) → Data_o=0x0FFFF, no wrap to negative.
- **Round-robin:** all four channels strobe in the same cycle with values 0x40000·(c+1) → four consecutive DataValid_o pulses with Chan_o 0,1,2,3 and Data_o 1,2,3,4. A second simultaneous burst yields the same order.
- **Overflow:** channels 0–3 each strobe every cycle for 6 cycles → Full_o rises, drops set Overflow_o for the overfilled channels. Per-channel accepted samples appear in input order. ClrOvf_i clears the flags; a simultaneous new drop keeps the bit set.
- **Simultaneous push/pop:** channel 2 is full and granted while strobing → the sample is accepted and Overflow_o[2] stays 0.
- **Reset mid-operation:** assert Rst_i while all FIFOs hold data → all outputs 0 immediately. After release, no stale results appear and the first grant goes to channel 0.
